// File: rtl/smips_multicycle.sv
// Multi-cycle MIPS-subset core: one shared req/ready memory port, FSM-sequenced datapath,
// trap-to-HALT on illegal or misaligned instructions when TRAP_EN is set.
module smips_multicycle #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          TRAP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [31:0]       pc_out,
  output logic              halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d;
  logic [31:0][31:0] rf_q, rf_d;
  logic req_q, req_d, we_q, we_d, halt_q, halt_d;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wb_reg;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal;
  logic [31:0] r_res, eaddr, wb_data;

  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];

  assign is_r    = (op == 6'h00) && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

  assign eaddr   = a_q + imm_q;
  assign wb_reg  = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr_q : alu_q;

  always_comb begin
    r_res = 32'h0;
    unique case (funct)
      6'h20:   r_res = a_q + b_q;
      6'h22:   r_res = a_q - b_q;
      6'h24:   r_res = a_q & b_q;
      6'h25:   r_res = a_q | b_q;
      default: r_res = {31'h0, $signed(a_q) < $signed(b_q)};
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_d    = rf_q;
    retire  = 1'b0;
    unique case (state_q)
      S_FETCH: if (req_q && mem_ready) begin
        ir_d    = mem_rdata;
        npc_d   = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
        state_d = (!legal && TRAP_EN) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // Without traps, illegal and misaligned instructions retire here as NOPs.
        if (!legal) begin
          pc_d = npc_q; retire = 1'b1; state_d = S_FETCH;
        end else if (is_r) begin
          alu_d = r_res; state_d = S_WB;
        end else if (is_addi) begin
          alu_d = eaddr; state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d = eaddr;
          if (eaddr[1:0] == 2'b00) state_d = S_MEM;
          else if (TRAP_EN)        state_d = S_HALT;
          else begin
            pc_d = npc_q; retire = 1'b1; state_d = S_FETCH;
          end
        end else if (is_beq) begin
          pc_d = (a_q == b_q) ? npc_q + {imm_q[29:0], 2'b00} : npc_q;
          retire = 1'b1; state_d = S_FETCH;
        end else begin
          pc_d = {npc_q[31:28], ir_q[25:0], 2'b00};
          retire = 1'b1; state_d = S_FETCH;
        end
      end
      S_MEM: if (req_q && mem_ready) begin
        if (is_sw) begin
          pc_d = npc_q; retire = 1'b1; state_d = S_FETCH;
        end else begin
          mdr_d = mem_rdata; state_d = S_WB;
        end
      end
      S_WB: begin
        if (wb_reg != 5'd0) rf_d[wb_reg] = wb_data;
        pc_d = npc_q; retire = 1'b1; state_d = S_FETCH;
      end
      default: ;
    endcase
    // Port outputs are registered from the next state, so the first fetch request
    // appears one cycle after reset is released.
    req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
    we_d    = (state_d == S_MEM) && is_sw;
    halt_d  = (state_d == S_HALT);
    maddr_d = (state_d == S_MEM) ? alu_d : pc_d;
    wdata_d = (state_d == S_MEM) ? b_q : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      npc_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      rf_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      rf_q    <= rf_d;
      req_q   <= req_d;
      we_q    <= we_d;
      halt_q  <= halt_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign pc_out    = pc_q;
  assign halted    = halt_q;
endmodule

// File: tb/tb_smips_multicycle.sv
// Scoreboard bench for smips_multicycle: directed programs with hand-computed retire PCs,
// inter-retire cycle gaps and store transactions; a second core checks TRAP_EN=0.
module tb_smips_multicycle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // core under test with a wait-state memory model
  logic rst_n = 1'b0;
  logic mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic [31:0] mem [256];
  int wait_n = 0, cnt = 0, cyc = 0;
  logic ld_en = 1'b0;
  logic [7:0] ld_idx = '0;
  logic [31:0] ld_data = '0;

  smips_multicycle dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .retire(retire),
    .pc_out(pc_out), .halted(halted));

  assign mem_ready = mem_req && (cnt >= wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
    cyc <= rst_n ? cyc + 1 : 0;
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // second core: TRAP_EN=0, 16-bit address port, zero-wait ROM
  logic rst2_n = 1'b0;
  logic req2, we2, ret2, halt2;
  logic [15:0] addr2;
  logic [31:0] wdata2, rdata2, pc2;
  int cyc2 = 0;

  function automatic logic [31:0] rom2(input logic [15:0] a);
    case (a)
      16'h0000: return ILL;
      16'h0004: return i_op(6'h08, 0, 1, 16'd3);
      16'h0008: return i_op(6'h23, 0, 2, 16'h0002);
      16'h000C: return i_op(6'h2B, 0, 1, 16'h0040);
      default:  return ILL;
    endcase
  endfunction

  smips_multicycle #(.ADDR_W(16), .RESET_PC(32'h0), .TRAP_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(1'b1), .retire(ret2),
    .pc_out(pc2), .halted(halt2));

  assign rdata2 = rom2(addr2);
  always @(posedge clk) cyc2 <= rst2_n ? cyc2 + 1 : 0;

  // scoreboard
  typedef struct { logic [31:0] pc; int gap; } ret_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
  ret_t exp_ret[$], exp_ret2[$];
  st_t  exp_st[$], exp_st2[$];
  int n_chk = 0, n_fail = 0, last_ret = 0, last_ret2 = 0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic er(input logic [31:0] pc, input int gap); exp_ret.push_back('{pc, gap}); endtask
  task automatic es(input logic [31:0] a, input logic [31:0] d); exp_st.push_back('{a, d}); endtask

  task automatic mon_step();
    ret_t r;
    st_t s;
    if (!rst_n) begin
      last_ret = 0; prev_wait = 1'b0;
    end else begin
      if (retire) begin
        if (exp_ret.size() == 0) chk("unexpected_retire_pc", pc_out, 32'hFFFF_FFFF);
        else begin
          r = exp_ret.pop_front();
          chk("retire_pc", pc_out, r.pc);
          chk("retire_gap", cyc - last_ret, r.gap);
        end
        last_ret = cyc;
      end
      if (mem_req && mem_ready && mem_we) begin
        if (exp_st.size() == 0) chk("unexpected_store_addr", mem_addr, 32'hFFFF_FFFF);
        else begin
          s = exp_st.pop_front();
          chk("store_addr", mem_addr, s.addr);
          chk("store_data", mem_wdata, s.data);
        end
      end
      if (mem_req && prev_wait) begin
        chk("wait_addr_stable", mem_addr, prev_addr);
        chk("wait_wdata_stable", mem_wdata, prev_wdata);
      end
      prev_wait = mem_req && !mem_ready;
      prev_addr = mem_addr;
      prev_wdata = mem_wdata;
    end
    if (!rst2_n) last_ret2 = 0;
    else begin
      if (ret2) begin
        if (exp_ret2.size() == 0) chk("unexpected_retire2_pc", pc2, 32'hFFFF_FFFF);
        else begin
          r = exp_ret2.pop_front();
          chk("retire2_pc", pc2, r.pc);
          chk("retire2_gap", cyc2 - last_ret2, r.gap);
        end
        last_ret2 = cyc2;
      end
      if (req2 && we2) begin
        if (exp_st2.size() == 0) chk("unexpected_store2_addr", {16'h0, addr2}, 32'hFFFF_FFFF);
        else begin
          s = exp_st2.pop_front();
          chk("store2_addr", {16'h0, addr2}, s.addr);
          chk("store2_data", wdata2, s.data);
        end
      end
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_idx = a[9:2]; ld_data = d; ld_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rst_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_rst_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, "_rst_halted"}, {31'h0, halted}, 32'h0);
    chk({tag, "_rst_retire"}, {31'h0, retire}, 32'h0);
    chk({tag, "_rst_pc"}, pc_out, 32'h0);
    chk({tag, "_rst_mem_addr"}, mem_addr, 32'h0);
  endtask

  task automatic release_rst();
    ld_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int delta);
    int t = 0;
    while (!halted && t < 2000) begin @(negedge clk); t++; end
    chk({tag, "_halted"}, {31'h0, halted}, 32'h1);
    chk({tag, "_halt_latency"}, cyc - last_ret, delta);
    repeat (3) @(negedge clk);
    chk({tag, "_halt_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, "_halt_sticky"}, {31'h0, halted}, 32'h1);
    chk({tag, "_ret_drained"}, exp_ret.size(), 0);
    chk({tag, "_st_drained"}, exp_st.size(), 0);
  endtask

  initial begin
    int t;
    fork
      forever begin @(negedge clk); mon_step(); end
    join_none

    // Run 1: zero-wait ALU, branches, jump, r0, stores of results, lw, trap
    wait_n = 0;
    load(32'h000, i_op(6'h08, 0, 1, 16'd5));
    load(32'h004, i_op(6'h08, 0, 2, 16'd7));
    load(32'h008, r_op(1, 2, 3, 6'h20));
    load(32'h00C, r_op(1, 2, 6, 6'h22));
    load(32'h010, i_op(6'h04, 1, 1, 16'd2));
    load(32'h014, ILL);
    load(32'h018, ILL);
    load(32'h01C, i_op(6'h04, 1, 2, 16'd5));
    load(32'h020, {6'h02, 26'h40});
    load(32'h100, i_op(6'h08, 0, 0, 16'd9));
    load(32'h104, r_op(0, 0, 5, 6'h20));
    load(32'h108, r_op(6, 1, 7, 6'h2A));
    load(32'h10C, i_op(6'h2B, 0, 3, 16'h0200));
    load(32'h110, i_op(6'h2B, 0, 5, 16'h0204));
    load(32'h114, i_op(6'h2B, 0, 6, 16'h0208));
    load(32'h118, i_op(6'h2B, 0, 7, 16'h020C));
    load(32'h11C, r_op(1, 2, 8, 6'h24));
    load(32'h120, r_op(1, 2, 9, 6'h25));
    load(32'h124, i_op(6'h2B, 0, 8, 16'h0210));
    load(32'h128, i_op(6'h2B, 0, 9, 16'h0214));
    load(32'h12C, i_op(6'h23, 0, 4, 16'h0200));
    load(32'h130, i_op(6'h2B, 0, 4, 16'h0218));
    load(32'h134, ILL);
    reset_checks("r1");
    er(32'h000, 4); er(32'h004, 4); er(32'h008, 4); er(32'h00C, 4);
    er(32'h010, 3); er(32'h01C, 3); er(32'h020, 3);
    er(32'h100, 4); er(32'h104, 4); er(32'h108, 4);
    er(32'h10C, 4); er(32'h110, 4); er(32'h114, 4); er(32'h118, 4);
    er(32'h11C, 4); er(32'h120, 4); er(32'h124, 4); er(32'h128, 4);
    er(32'h12C, 5); er(32'h130, 4);
    es(32'h200, 32'd12); es(32'h204, 32'd0); es(32'h208, 32'hFFFF_FFFE); es(32'h20C, 32'd1);
    es(32'h210, 32'd5); es(32'h214, 32'd7); es(32'h218, 32'd12);
    release_rst();
    wait_halt("r1", 3);

    // Run 2: three wait states on every access
    rst_n = 1'b0; wait_n = 3;
    load(32'h000, i_op(6'h08, 0, 3, 16'd12));
    load(32'h004, i_op(6'h2B, 0, 3, 16'h0004));
    load(32'h008, i_op(6'h23, 0, 4, 16'h0004));
    load(32'h00C, i_op(6'h2B, 0, 4, 16'h0200));
    load(32'h010, ILL);
    er(32'h000, 7); er(32'h004, 10); er(32'h008, 11); er(32'h00C, 10);
    es(32'h004, 32'd12); es(32'h200, 32'd12);
    release_rst();
    wait_halt("r2", 6);

    // Run 3: misaligned lw traps
    rst_n = 1'b0; wait_n = 0;
    load(32'h000, i_op(6'h08, 0, 1, 16'd2));
    load(32'h004, i_op(6'h23, 1, 2, 16'h0000));
    er(32'h000, 4);
    release_rst();
    wait_halt("r3", 4);

    // Run 4: reset in the middle of a store wait, then prove r1 was cleared
    rst_n = 1'b0; wait_n = 5;
    load(32'h000, i_op(6'h08, 0, 1, 16'd1));
    load(32'h004, i_op(6'h2B, 0, 1, 16'h0200));
    reset_checks("r4");
    er(32'h000, 9);
    release_rst();
    t = 0;
    while (!(mem_req && mem_we) && t < 500) begin @(negedge clk); t++; end
    chk("r4_store_pending", {31'h0, mem_req && mem_we}, 32'h1);
    chk("r4_store_waiting", {31'h0, mem_ready}, 32'h0);
    chk("r4_store_pc", pc_out, 32'h4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r4_abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("r4_abort_pc", pc_out, 32'h0);
    chk("r4_abort_halted", {31'h0, halted}, 32'h0);
    chk("r4_abort_ret_drained", exp_ret.size(), 0);
    wait_n = 0;
    load(32'h000, i_op(6'h2B, 0, 1, 16'h0204));
    load(32'h004, ILL);
    er(32'h000, 4);
    es(32'h204, 32'd0);
    release_rst();
    wait_halt("r4", 3);

    // Run 5: TRAP_EN=0 core treats illegal and misaligned as NOPs
    exp_ret2.push_back('{32'h0, 3});
    exp_ret2.push_back('{32'h4, 4});
    exp_ret2.push_back('{32'h8, 3});
    exp_ret2.push_back('{32'hC, 4});
    exp_st2.push_back('{32'h40, 32'd3});
    rst2_n = 1'b1;
    t = 0;
    while ((exp_ret2.size() != 0 || exp_st2.size() != 0) && t < 200) begin @(negedge clk); t++; end
    chk("r5_ret2_drained", exp_ret2.size(), 0);
    chk("r5_st2_drained", exp_st2.size(), 0);
    chk("r5_not_halted", {31'h0, halt2}, 32'h0);
    rst2_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
